// File: rtl/cpu_pkg.sv
// Shared CPU constants: architectural register indices, datapath widths and
// the stack pointer reset value used by the register bank and write-register mux.
package cpu_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;

    localparam int REG_ZERO     = 0;
    localparam int REG_SP       = 29;
    localparam int REG_RA       = 31;

    localparam int SP_RESET_VAL = 227;

endpackage

// File: rtl/reg_bypass_read.sv
// One read port of the register bank: register 0 forced to zero, same-cycle
// write data forwarded ahead of storage, otherwise the stored value.
module reg_bypass_read
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic [DATA_W-1:0]            rd_data_o
);

    // Forwarding lets a write and an operand capture on the same edge agree.
    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i != ADDR_W'(REG_ZERO)) begin
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_o = wr_data_i;
            end else begin
                rd_data_o = regs_i[rd_addr_i];
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register file for the multicycle CPU: 32 architectural registers, one write
// port, two bypassed read ports captured into the A/B operand latches.
module reg_bank
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int SP_RESET = cpu_pkg::SP_RESET_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              ab_load,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] rd_a_raw,
    output logic              wr_zero_attempt
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]            a_q, b_q;
    logic                         zero_wr_q;
    logic [DATA_W-1:0]            rd_a_d, rd_b_d;
    logic                         wr_is_zero;

    assign wr_is_zero = (wr_addr == ADDR_W'(REG_ZERO));

    reg_bypass_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_read_a (
        .regs_i    (regs_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_a),
        .rd_data_o (rd_a_d)
    );

    reg_bypass_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_read_b (
        .regs_i    (regs_q),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr_b),
        .rd_data_o (rd_b_d)
    );

    // Register 0 is never written, so its reset value of zero is permanent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[REG_SP] <= DATA_W'(SP_RESET);
        end else if (wr_en && !wr_is_zero) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            zero_wr_q <= 1'b0;
        end else begin
            if (ab_load) begin
                a_q <= rd_a_d;
                b_q <= rd_b_d;
            end
            if (wr_en && wr_is_zero) begin
                zero_wr_q <= 1'b1;
            end
        end
    end

    assign a_out           = a_q;
    assign b_out           = b_q;
    assign rd_a_raw        = rd_a_d;
    assign wr_zero_attempt = zero_wr_q;

endmodule

// File: doc/reg_bank.md
# reg_bank

Register file for the multicycle CPU: the read-side counterpart to the write-register select logic. It holds 32 architectural 32-bit registers. It accepts one write per cycle at the 5-bit destination index chosen by the write-register mux (rd, rt, 29 or 31). It serves two source reads (rs, rt) into registered A/B operand latches, which feed the ALU muxes in the execute cycle.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- SP_RESET, 227, reset value of register 29 (stack pointer)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wr_en  input  1  register write strobe
- wr_addr  input  ADDR_W  destination index (from write-register mux)
- wr_data  input  DATA_W  write data (from memory-to-reg mux)
- rd_addr_a  input  ADDR_W  source index rs (instruction[25:21])
- rd_addr_b  input  ADDR_W  source index rt (instruction[20:16])
- ab_load  input  1  capture both read ports into A/B this edge
- a_out  output  DATA_W  A operand latch
- b_out  output  DATA_W  B operand latch
- rd_a_raw  output  DATA_W  combinational read of rd_addr_a (bypassed), for the branch compare path
- wr_zero_attempt  output  1  sticky flag: a write to register 0 was issued since reset

## Operation
- Storage: 32 × DATA_W registers. Register 0 reads as 0 at all times and is never written.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
- Write with wr_addr=0: storage unchanged; wr_zero_attempt ← 1. It stays 1 until reset.
- Read: rd_a_raw = (wr_en && wr_addr==rd_addr_a && rd_addr_a≠0) ? wr_data : reg[rd_addr_a]; 0 if rd_addr_a=0. Port B is computed the same way internally.
- A/B latch: on a rising edge with ab_load=1, a_out ← bypassed read A and b_out ← bypassed read B. With ab_load=0, both latches hold.
- Bypass rule: a write and an ab_load on the same edge to the same index deliver the new wr_data to A/B, never the stale value.
- Index 29 with ab_load after reset and no write yields SP_RESET.
- Reset (reset=0, asynchronous, immediate):
  - all registers = 0, except reg[29] = SP_RESET
  - a_out = 0, b_out = 0, wr_zero_attempt = 0
- Reset asserted mid-write: the write is lost and reset values win. Reset deassertion takes effect on the next edge.
- No state machine. The control unit sequences ab_load (decode cycle) and wr_en (writeback cycle).

## Timing
- Write latency: 1 edge. Data is visible in storage and on raw reads after the edge. Through the bypass, it is visible combinationally in the same cycle.
- A/B latency: 1 edge after ab_load.
- rd_a_raw: purely combinational from addresses and the write port. No registered path.
- Simultaneous wr_en and ab_load on different indices: independent, both complete on the same edge.
- Both read indices equal to wr_addr: both A and B get wr_data.

## Structure
- Shared CPU package (cpu_pkg) holds the constants:
  - REG_ZERO=0, REG_SP=29, REG_RA=31
  - SP_RESET_VAL=227
  - DATA_W, ADDR_W
- The write-register mux uses the same REG_SP/REG_RA constants.
- One sub-module, reg_bypass_read: the combinational zero/bypass/select for one read port. It is instantiated twice, for A and B.
- Storage and the A/B latches live in reg_bank.

## Test plan
- Reset, then ab_load with rd_addr_a=29, rd_addr_b=0 -> a_out=227, b_out=0; wr_zero_attempt=0.
- Write reg[8]=0xDEADBEEF, next cycle ab_load rs=8, rt=8 -> a_out=b_out=0xDEADBEEF.
- Same-edge bypass: wr_en with wr_addr=31, wr_data=0x00400008, plus ab_load with rs=31 -> a_out=0x00400008 after that edge; rd_a_raw=0x00400008 before the edge.
- Write index 0 with 0xFFFFFFFF -> reads of 0 return 0; wr_zero_attempt=1 and stays 1 through further writes.
- ab_load=0 while writing reg[5] that A currently holds -> a_out unchanged until the next ab_load.
- Assert reset mid-sequence after writing reg[29]=0x10 -> a_out=b_out=0 immediately; a subsequent read of 29 returns 227.
